// File: rtl/tick_rate_controller_if.sv
// Configuration handshake for the tick rate controller: a divide ratio offered
// over valid/ready, with a one-cycle error pulse when a zero ratio is rejected.
interface tick_rate_controller_if #(
   parameter int CNT_W = 23
);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_div,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_div,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/tick_rate_controller.sv
// Programmable divider: one-cycle tick per period plus a 50%-duty clock_out.
// New ratios take effect only at a period boundary (or while stopped) so clock_out never glitches.
module tick_rate_controller #(
   parameter int CNT_W       = 23,
   parameter int DEFAULT_DIV = 5_000_000
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic                 enable,
   tick_rate_controller_if.slave cfg,
   output logic                 tick,
   output logic                 clock_out,
   output logic [CNT_W-1:0]     active_div,
   output logic                 running
);

   typedef enum logic [1:0] {
      STOP,
      RUN,
      PEND
   } state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] pendDiv_q;
   logic [CNT_W-1:0] activeDiv_q;
   logic             clockOut_q;
   logic             tick_q;
   logic             cfgReady_q;
   logic             cfgErr_q;
   logic             running_q;

   logic             offer;
   logic             transfer;
   logic             rejectZero;
   logic             wrap;

   // A zero ratio is never transferred; it only raises cfg_err on the next cycle.
   assign offer      = cfg.cfg_valid & cfgReady_q;
   assign transfer   = offer & (cfg.cfg_div != '0);
   assign rejectZero = offer & (cfg.cfg_div == '0);
   assign wrap       = (state_q != STOP) && (count_q == activeDiv_q - ONE);
   assign count_d    = count_q + ONE;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= STOP;
         count_q     <= '0;
         pendDiv_q   <= '0;
         activeDiv_q <= DEF_DIV;
         clockOut_q  <= 1'b0;
         tick_q      <= 1'b0;
         cfgReady_q  <= 1'b1;
         cfgErr_q    <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         tick_q   <= 1'b0;
         cfgErr_q <= rejectZero;
         case (state_q)
            STOP: begin
               count_q <= '0;
               if (transfer) begin
                  activeDiv_q <= cfg.cfg_div;
               end
               if (enable) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  // Stopping discards the partial period; a same-cycle ratio needs no deferral.
                  state_q   <= STOP;
                  running_q <= 1'b0;
                  count_q   <= '0;
                  if (transfer) begin
                     activeDiv_q <= cfg.cfg_div;
                  end
               end else begin
                  if (wrap) begin
                     count_q    <= '0;
                     tick_q     <= 1'b1;
                     clockOut_q <= ~clockOut_q;
                  end else begin
                     count_q <= count_d;
                  end
                  if (transfer) begin
                     pendDiv_q  <= cfg.cfg_div;
                     cfgReady_q <= 1'b0;
                     state_q    <= PEND;
                  end
               end
            end
            PEND: begin
               // Dropping enable wins over a coincident wrap, so no tick on that edge.
               if (!enable) begin
                  activeDiv_q <= pendDiv_q;
                  count_q     <= '0;
                  cfgReady_q  <= 1'b1;
                  state_q     <= STOP;
                  running_q   <= 1'b0;
               end else if (wrap) begin
                  activeDiv_q <= pendDiv_q;
                  count_q     <= '0;
                  tick_q      <= 1'b1;
                  clockOut_q  <= ~clockOut_q;
                  cfgReady_q  <= 1'b1;
                  state_q     <= RUN;
               end else begin
                  count_q <= count_d;
               end
            end
            default: begin
               state_q   <= STOP;
               running_q <= 1'b0;
               count_q   <= '0;
            end
         endcase
      end
   end

   assign tick          = tick_q;
   assign clock_out     = clockOut_q;
   assign active_div    = activeDiv_q;
   assign running       = running_q;
   assign cfg.cfg_ready = cfgReady_q;
   assign cfg.cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller with a small divider (DEFAULT_DIV=4, CNT_W=8);
// expected values are hand-computed per clock edge.
module tb_tick_rate_controller;

   localparam int CNT_W = 8;

   logic             clock_in;
   logic             reset_n;
   logic             enable;
   logic             tick;
   logic             clock_out;
   logic [CNT_W-1:0] active_div;
   logic             running;

   int checks   = 0;
   int failures = 0;

   tick_rate_controller_if #(.CNT_W(CNT_W)) cfgIf ();

   tick_rate_controller #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(4)
   ) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable),
      .cfg       (cfgIf.slave),
      .tick      (tick),
      .clock_out (clock_out),
      .active_div(active_div),
      .running   (running)
   );

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic valid, input logic [CNT_W-1:0] div);
      enable          = en;
      cfgIf.cfg_valid = valid;
      cfgIf.cfg_div   = div;
   endtask

   // One posedge, then settle to the following negedge where outputs are sampled.
   task automatic step();
      @(posedge clock_in);
      @(negedge clock_in);
   endtask

   initial begin
      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, '0);
      step();
      step();

      // Test 1: reset values, then default ratio of 4
      checkOutput("rst_tick",    tick,       0);
      checkOutput("rst_clkout",  clock_out,  0);
      checkOutput("rst_ready",   cfgIf.cfg_ready, 1);
      checkOutput("rst_err",     cfgIf.cfg_err,   0);
      checkOutput("rst_running", running,    0);
      checkOutput("rst_active",  active_div, 4);

      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("t1_running", running, 1);
      checkOutput("t1_tick0",   tick,    0);
      for (int i = 1; i <= 8; i++) begin
         step();
         checkOutput($sformatf("t1_tick%0d", i), tick, (i % 4 == 0) ? 1 : 0);
         checkOutput($sformatf("t1_clk%0d", i), clock_out, (i >= 4 && i < 8) ? 1 : 0);
      end

      // Test 2: offer 2 at count=1; old ratio finishes its period first
      step();
      applyStimulus(1'b1, 1'b1, 8'd2);
      step();
      checkOutput("t2_ready_low",  cfgIf.cfg_ready, 0);
      checkOutput("t2_active_old", active_div, 4);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("t2_notick", tick, 0);
      step();
      checkOutput("t2_wrap_tick",   tick, 1);
      checkOutput("t2_active_new",  active_div, 2);
      checkOutput("t2_ready_back",  cfgIf.cfg_ready, 1);
      checkOutput("t2_clk_wrap",    clock_out, 1);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkOutput($sformatf("t2_tick%0d", i), tick, (i % 2 == 0) ? 1 : 0);
      end
      checkOutput("t2_clk_end", clock_out, 1);

      // Test 3: zero ratio is rejected with a one-cycle error
      applyStimulus(1'b1, 1'b1, 8'd0);
      step();
      checkOutput("t3_err",    cfgIf.cfg_err,   1);
      checkOutput("t3_ready",  cfgIf.cfg_ready, 1);
      checkOutput("t3_active", active_div, 2);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("t3_err_clear", cfgIf.cfg_err, 0);
      checkOutput("t3_tick",      tick, 1);
      checkOutput("t3_clk",       clock_out, 0);

      // Test 4: drop enable in PEND on the would-be wrap edge
      applyStimulus(1'b1, 1'b1, 8'd6);
      step();
      checkOutput("t4_pend_ready", cfgIf.cfg_ready, 0);
      applyStimulus(1'b0, 1'b0, '0);
      step();
      checkOutput("t4_notick",  tick, 0);
      checkOutput("t4_clkhold", clock_out, 0);
      checkOutput("t4_active",  active_div, 6);
      checkOutput("t4_ready",   cfgIf.cfg_ready, 1);
      checkOutput("t4_stopped", running, 0);
      step();
      checkOutput("t4_idle_tick", tick, 0);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("t4_rerun", running, 1);
      for (int i = 1; i <= 6; i++) begin
         step();
         checkOutput($sformatf("t4_tick%0d", i), tick, (i == 6) ? 1 : 0);
      end
      checkOutput("t4_clk_end", clock_out, 1);

      // Test 5: ratio 1 via a transfer coincident with stopping, then tick every cycle
      applyStimulus(1'b0, 1'b1, 8'd1);
      step();
      checkOutput("t5_active",  active_div, 1);
      checkOutput("t5_stopped", running, 0);
      checkOutput("t5_clkhold", clock_out, 1);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("t5_run_tick", tick, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkOutput($sformatf("t5_tick%0d", i), tick, 1);
         checkOutput($sformatf("t5_clk%0d", i), clock_out, (i % 2 == 0) ? 1 : 0);
      end

      // Test 6: ratio applied while stopped, then async reset in the middle of PEND
      applyStimulus(1'b0, 1'b0, '0);
      step();
      checkOutput("t6_stop_clk", clock_out, 1);
      applyStimulus(1'b0, 1'b1, 8'd5);
      step();
      checkOutput("t6_stop_active", active_div, 5);
      checkOutput("t6_stop_ready",  cfgIf.cfg_ready, 1);
      checkOutput("t6_stop_run",    running, 0);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      step();
      applyStimulus(1'b1, 1'b1, 8'd7);
      step();
      checkOutput("t6_pend_ready", cfgIf.cfg_ready, 0);
      applyStimulus(1'b0, 1'b0, '0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t6_async_active",  active_div, 4);
      checkOutput("t6_async_ready",   cfgIf.cfg_ready, 1);
      checkOutput("t6_async_running", running, 0);
      checkOutput("t6_async_clk",     clock_out, 0);
      checkOutput("t6_async_tick",    tick, 0);
      checkOutput("t6_async_err",     cfgIf.cfg_err, 0);
      @(negedge clock_in);
      reset_n = 1'b1;
      step();
      checkOutput("t6_post_active", active_div, 4);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      for (int i = 1; i <= 4; i++) begin
         step();
         checkOutput($sformatf("t6_tick%0d", i), tick, (i == 4) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
